// File: rtl/waveform_loader_if.sv
// Stream and BRAM write-port bundle for the waveform loader.
//
// Signals:
//   s_data / s_valid / s_last  sample stream from the source
//   s_ready                    loader accepts a sample this cycle
//   bram_we / bram_addr / bram_din  BRAM port A write signals
//
// Modports:
//   slave  - loader view (consumes the stream, drives BRAM port A)
//   master - environment view (drives the stream, observes BRAM port A)
interface waveform_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;

  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready,
    output bram_we,
    output bram_addr,
    output bram_din
  );

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready,
    input  bram_we,
    input  bram_addr,
    input  bram_din
  );

endinterface

// File: rtl/waveform_loader.sv
// Loads one complete waveform table (DEPTH = 2**ADDR_WIDTH samples) from a
// valid/ready sample stream into BRAM port A, and reports whether the table
// is clean and full so playback can be enabled only on a good table.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        pulse, begins a load (only honoured in IDLE)
//   abort        pulse, cancels an in-progress load (only honoured in LOAD)
//   bus          stream input + BRAM port A output (waveform_loader_if.slave)
//   busy         high while loading
//   done         one-cycle pulse when a load finishes (clean or errored)
//   table_valid  clean full table present; cleared by start
//   err_short    sticky, s_last seen before the final address
//   err_long     sticky, final address written without s_last
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; stream not accepted
// LOAD  | accepting samples, writing BRAM at wr_ptr
// DONE  | one-cycle completion state, drives done; returns to IDLE
module waveform_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  waveform_loader_if.slave        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    table_valid,
  output logic                    err_short,
  output logic                    err_long
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  s_ready_int;
  logic                  xfer;
  logic                  at_last_addr;
  logic                  load_start;
  logic                  bram_we_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [DATA_WIDTH-1:0] bram_din_q;

  // s_ready already excludes abort, so an aborting cycle never transfers.
  assign xfer         = bus.s_valid && s_ready_int;
  assign at_last_addr = (wr_ptr == LAST_ADDR);
  assign load_start   = (state == ST_IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (xfer && (at_last_addr || bus.s_last)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode; busy/done come straight from the state register.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    s_ready_int = 1'b0;
    case (state)
      ST_LOAD: begin
        busy        = 1'b1;
        s_ready_int = !abort;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy        = 1'b0;
      end
    endcase
  end

  // Write pointer and BRAM port A registers. Address and data hold their
  // last value when no sample is taken; only we drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      bram_we_q <= xfer;
      if (load_start) begin
        wr_ptr <= '0;
      end else if (xfer) begin
        wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
        bram_addr_q <= wr_ptr;
        bram_din_q  <= bus.s_data;
      end
    end
  end

  // Table status flags, cleared only by an accepted start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else if (load_start) begin
      table_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else if (xfer) begin
      if (at_last_addr) begin
        if (bus.s_last) begin
          table_valid <= 1'b1;
        end else begin
          err_long <= 1'b1;
        end
      end else if (bus.s_last) begin
        err_short <= 1'b1;
      end
    end
  end

  assign bus.s_ready   = s_ready_int;
  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_din  = bram_din_q;

endmodule
